// File: rtl/esp_dma_pkg.sv
// Shared types and constants for the ESP DMA 64-bit protocol responders.
package esp_dma_pkg;

    localparam logic [31:0] DMA_BEAT_BYTES = 32'd8;
    localparam logic [2:0]  DMA_SIZE_DWORD = 3'b011;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        RD_OUT  = 3'd3,
        WR_IN   = 3'd4,
        WR_REQ  = 3'd5,
        WR_WAIT = 3'd6
    } dma_state_e;

    // Byte address of a beat index; wraps modulo 2^32.
    function automatic logic [31:0] dma_index_to_addr(input logic [31:0] base,
                                                      input logic [31:0] index);
        return base + index * DMA_BEAT_BYTES;
    endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by every OBI master and slave in the slice.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/esp_dma64_obi_responder.sv
// Serves ESP DMA 64-bit read/write commands as pairs of 32-bit OBI accesses,
// one command and one OBI transaction in flight at a time.
module esp_dma64_obi_responder
    import esp_dma_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               dma_read_ctrl_valid,
    output logic               dma_read_ctrl_ready,
    input  logic [31:0]        dma_read_ctrl_data_index,
    input  logic [31:0]        dma_read_ctrl_data_length,
    input  logic [2:0]         dma_read_ctrl_data_size,
    input  logic [5:0]         dma_read_ctrl_data_user,

    output logic               dma_read_chnl_valid,
    input  logic               dma_read_chnl_ready,
    output logic [63:0]        dma_read_chnl_data,

    input  logic               dma_write_ctrl_valid,
    output logic               dma_write_ctrl_ready,
    input  logic [31:0]        dma_write_ctrl_data_index,
    input  logic [31:0]        dma_write_ctrl_data_length,
    input  logic [2:0]         dma_write_ctrl_data_size,
    input  logic [5:0]         dma_write_ctrl_data_user,

    input  logic               dma_write_chnl_valid,
    output logic               dma_write_chnl_ready,
    input  logic [63:0]        dma_write_chnl_data,

    output obi_pkg::obi_req_t  obi_req_o,
    input  obi_pkg::obi_resp_t obi_resp_i,

    output logic               busy,
    output logic               done_o
);

    dma_state_e  state_q;
    logic [31:0] addr_q;
    logic [31:0] remaining_q;
    logic        half_q;
    logic [63:0] rd_beat_q;
    logic [63:0] wr_beat_q;
    logic        done_q;

    logic        rd_cmd_acc;
    logic        wr_cmd_acc;
    logic [31:0] cmd_index;
    logic [31:0] cmd_length;
    logic        last_beat;

    // Size and user fields carry no meaning here: every beat is a full 64-bit word.
    logic unused_cmd_fields;
    assign unused_cmd_fields = ^{dma_read_ctrl_data_size, dma_read_ctrl_data_user,
                                 dma_write_ctrl_data_size, dma_write_ctrl_data_user};

    assign dma_read_ctrl_ready  = (state_q == IDLE);
    assign dma_write_ctrl_ready = (state_q == IDLE);

    // Read wins a simultaneous request; the write simply stays pending on its valid.
    assign rd_cmd_acc = (state_q == IDLE) && dma_read_ctrl_valid;
    assign wr_cmd_acc = (state_q == IDLE) && !dma_read_ctrl_valid && dma_write_ctrl_valid;

    assign cmd_index  = rd_cmd_acc ? dma_read_ctrl_data_index  : dma_write_ctrl_data_index;
    assign cmd_length = rd_cmd_acc ? dma_read_ctrl_data_length : dma_write_ctrl_data_length;
    assign last_beat  = (remaining_q == 32'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            half_q      <= 1'b0;
            rd_beat_q   <= '0;
            wr_beat_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rd_cmd_acc || wr_cmd_acc) begin
                        addr_q      <= dma_index_to_addr(BASE_ADDR, cmd_index);
                        remaining_q <= cmd_length;
                        half_q      <= 1'b0;
                        if (cmd_length == 32'd0) begin
                            done_q <= 1'b1;
                        end else if (rd_cmd_acc) begin
                            state_q <= RD_REQ;
                        end else begin
                            state_q <= WR_IN;
                        end
                    end
                end

                RD_REQ: begin
                    if (obi_resp_i.gnt) begin
                        state_q <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (obi_resp_i.rvalid) begin
                        if (!half_q) begin
                            rd_beat_q[31:0] <= obi_resp_i.rdata;
                            half_q          <= 1'b1;
                            state_q         <= RD_REQ;
                        end else begin
                            rd_beat_q[63:32] <= obi_resp_i.rdata;
                            state_q          <= RD_OUT;
                        end
                    end
                end

                RD_OUT: begin
                    if (dma_read_chnl_ready) begin
                        remaining_q <= remaining_q - 32'd1;
                        addr_q      <= addr_q + DMA_BEAT_BYTES;
                        half_q      <= 1'b0;
                        if (last_beat) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RD_REQ;
                        end
                    end
                end

                WR_IN: begin
                    if (dma_write_chnl_valid) begin
                        wr_beat_q <= dma_write_chnl_data;
                        half_q    <= 1'b0;
                        state_q   <= WR_REQ;
                    end
                end

                WR_REQ: begin
                    if (obi_resp_i.gnt) begin
                        state_q <= WR_WAIT;
                    end
                end

                WR_WAIT: begin
                    if (obi_resp_i.rvalid) begin
                        if (!half_q) begin
                            half_q  <= 1'b1;
                            state_q <= WR_REQ;
                        end else if (last_beat) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q      <= addr_q + DMA_BEAT_BYTES;
                            remaining_q <= remaining_q - 32'd1;
                            state_q     <= WR_IN;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Request fields derive only from registered state, so they hold until gnt.
    always_comb begin
        obi_req_o = '0;
        if (state_q == RD_REQ || state_q == WR_REQ) begin
            obi_req_o.req  = 1'b1;
            obi_req_o.we   = (state_q == WR_REQ);
            obi_req_o.be   = 4'hF;
            obi_req_o.addr = addr_q + {29'd0, half_q, 2'b00};
            if (state_q == WR_REQ) begin
                obi_req_o.wdata = half_q ? wr_beat_q[63:32] : wr_beat_q[31:0];
            end
        end
    end

    assign dma_read_chnl_valid  = (state_q == RD_OUT);
    assign dma_read_chnl_data   = rd_beat_q;
    assign dma_write_chnl_ready = (state_q == WR_IN);

    assign busy   = (state_q != IDLE);
    assign done_o = done_q;

endmodule
